// File: rtl/serializador_sequencia.sv
// Serializes a programmed word MSB first, with filler prefix bits, inter-copy gaps
// and a repeat count; valid/ready handshake on the serial output.
module serializador_sequencia #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned PREFIX_LEN = 4,
   parameter bit          FILL_BIT   = 1'b0,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             setar_palavra,
   input  logic [WIDTH-1:0] palavra,
   input  logic [3:0]       repeticoes,
   input  logic             start,
   input  logic             bit_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned PW = (PREFIX_LEN > 1) ? $clog2(PREFIX_LEN) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned AW = (PW > GW) ? PW : GW;

   localparam logic [IW-1:0] IDX_MSB    = IW'(WIDTH - 1);
   localparam logic [AW-1:0] PRE_LAST   = AW'(PREFIX_LEN - 1);
   localparam logic [AW-1:0] GAP_LAST   = AW'(GAP_CYCLES - 1);
   localparam bit            HAS_PREFIX = (PREFIX_LEN != 0);
   localparam bit            HAS_GAP    = (GAP_CYCLES != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PREFIX = 3'd1,
      S_WORD   = 3'd2,
      S_GAP    = 3'd3,
      S_FIM    = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [3:0]       rep_q, rep_d;
   logic [3:0]       copies_q, copies_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [AW-1:0]    aux_q, aux_d;
   logic             bit_out_q, bit_out_d;
   logic             bit_valid_q, bit_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             xfer;

   assign xfer      = bit_valid_q & bit_ready;
   assign bit_out   = bit_out_q;
   assign bit_valid = bit_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         word_q      <= '0;
         rep_q       <= '0;
         copies_q    <= '0;
         idx_q       <= '0;
         aux_q       <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         rep_q       <= rep_d;
         copies_q    <= copies_d;
         idx_q       <= idx_d;
         aux_q       <= aux_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next state; aux counts filler transfers in PREFIX and idle cycles in GAP
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      rep_d    = rep_q;
      copies_d = copies_q;
      idx_d    = idx_q;
      aux_d    = aux_q;
      unique case (state_q)
         S_IDLE: begin
            if (setar_palavra) begin
               word_d = palavra;
               rep_d  = repeticoes;
            end else if (start) begin
               if (rep_q == 4'd0) begin
                  state_d = S_FIM;
               end else begin
                  copies_d = rep_q;
                  aux_d    = '0;
                  idx_d    = IDX_MSB;
                  if (HAS_PREFIX) state_d = S_PREFIX;
                  else            state_d = S_WORD;
               end
            end
         end
         S_PREFIX: begin
            if (xfer) begin
               if (aux_q == PRE_LAST) begin
                  aux_d   = '0;
                  idx_d   = IDX_MSB;
                  state_d = S_WORD;
               end else begin
                  aux_d = aux_q + AW'(1);
               end
            end
         end
         S_WORD: begin
            if (xfer) begin
               if (idx_q == '0) begin
                  copies_d = copies_q - 4'd1;
                  aux_d    = '0;
                  idx_d    = IDX_MSB;
                  if (copies_q == 4'd1)  state_d = S_FIM;
                  else if (HAS_GAP)      state_d = S_GAP;
                  else if (HAS_PREFIX)   state_d = S_PREFIX;
                  else                   state_d = S_WORD;
               end else begin
                  idx_d = idx_q - IW'(1);
               end
            end
         end
         S_GAP: begin
            if (aux_q == GAP_LAST) begin
               aux_d = '0;
               if (HAS_PREFIX) state_d = S_PREFIX;
               else            state_d = S_WORD;
            end else begin
               aux_d = aux_q + AW'(1);
            end
         end
         S_FIM:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the upcoming state so they register alongside it
   always_comb begin
      bit_out_d   = 1'b0;
      bit_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      unique case (state_d)
         S_PREFIX: begin
            bit_out_d   = FILL_BIT;
            bit_valid_d = 1'b1;
            busy_d      = 1'b1;
         end
         S_WORD: begin
            bit_out_d   = word_d[idx_d];
            bit_valid_d = 1'b1;
            busy_d      = 1'b1;
         end
         S_GAP:   busy_d = 1'b1;
         S_FIM:   done_d = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_serializador_sequencia.sv
// Directed and randomized bench for serializador_sequencia, checked against a
// queue-based model of the expected serial stream and its timing.
module tb_serializador_sequencia;

   localparam int unsigned W  = 8;
   localparam int unsigned P  = 4;
   localparam int unsigned G  = 2;
   localparam bit          FB = 1'b0;
   localparam int          BUDGET = 600;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         setar_palavra = 1'b0;
   logic [W-1:0] palavra = '0;
   logic [3:0]   repeticoes = '0;
   logic         start = 1'b0;
   logic         bit_ready = 1'b0;
   logic         bit_out, bit_valid, busy, done;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] m_word = '0;
   logic [3:0]   m_rep  = '0;
   bit           exp_q[$];
   bit           got[$];
   int           done_idx, busy_cnt, gap_cnt, vnb, hold_err;

   serializador_sequencia #(
      .WIDTH(W), .PREFIX_LEN(P), .FILL_BIT(FB), .GAP_CYCLES(G)
   ) dut (
      .clk(clk), .rst(rst), .setar_palavra(setar_palavra), .palavra(palavra),
      .repeticoes(repeticoes), .start(start), .bit_ready(bit_ready),
      .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Expected stream: every copy is P filler bits then the word MSB first
   function automatic void build_expected(input logic [W-1:0] w, input int rep);
      exp_q.delete();
      for (int c = 0; c < rep; c++) begin
         for (int i = 0; i < P; i++) exp_q.push_back(FB);
         for (int b = W - 1; b >= 0; b--) exp_q.push_back(w[b]);
      end
   endfunction

   // mode: 0 ready always, 1 ready toggling, 2 random ready; inj_at injects setar+start
   task automatic run_tx(input string tag, input bit do_load, input logic [W-1:0] w,
                         input logic [3:0] r, input int mode, input int inj_at);
      bit prev_stall = 1'b0;
      bit prev_bit   = 1'b0;
      bit rdy;
      int cyc  = 0;
      int mism = -1;
      int rep;
      if (do_load) begin
         setar_palavra = 1'b1; palavra = w; repeticoes = r;
         @(negedge clk);
         setar_palavra = 1'b0;
         m_word = w; m_rep = r;
      end
      rep = int'(m_rep);
      build_expected(m_word, rep);
      got.delete();
      done_idx = -1; busy_cnt = 0; gap_cnt = 0; vnb = 0; hold_err = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (done_idx < 0 && cyc < BUDGET) begin
         if (cyc == inj_at) begin
            setar_palavra = 1'b1; start = 1'b1; palavra = 8'h3C;
         end else begin
            setar_palavra = 1'b0; start = 1'b0;
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         bit_ready = rdy;
         if (prev_stall && (bit_valid !== 1'b1 || bit_out !== prev_bit)) hold_err++;
         if (bit_valid && rdy) got.push_back(bit_out);
         prev_stall = bit_valid && !rdy;
         prev_bit   = bit_out;
         if (busy) busy_cnt++;
         if (busy && !bit_valid) gap_cnt++;
         if (bit_valid && !busy) vnb++;
         if (done) done_idx = cyc;
         cyc++;
         @(negedge clk);
      end
      setar_palavra = 1'b0; start = 1'b0;
      chk({tag, "_finished"}, (done_idx >= 0), 1);
      chk({tag, "_done_single"}, done, 0);
      chk({tag, "_idle_after"}, busy, 0);
      chk({tag, "_nbits"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (mism < 0 && got[i] != exp_q[i]) mism = i;
      chk({tag, "_first_bad_bit"}, mism, -1);
      chk({tag, "_hold"}, hold_err, 0);
      chk({tag, "_valid_wo_busy"}, vnb, 0);
      chk({tag, "_gap_cycles"}, gap_cnt, (rep > 0) ? (rep - 1) * int'(G) : 0);
      if (mode == 0) begin
         if (rep > 0) begin
            chk({tag, "_busy_span"}, busy_cnt + 1, 1 + rep * int'(P + W) + (rep - 1) * int'(G));
            chk({tag, "_min_cycles"}, done_idx + 2, 1 + rep * int'(P + W) + (rep - 1) * int'(G) + 1);
         end else begin
            chk({tag, "_done_next"}, done_idx, 0);
            chk({tag, "_busy_cnt"}, busy_cnt, 0);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int late_done;
      // Reset values
      #12;
      chk("rst_bit_out", bit_out, 0);
      chk("rst_bit_valid", bit_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      bit_ready = 1'b1;
      @(negedge clk);

      run_tx("t1", 1'b1, 8'hA5, 4'd1, 0, -1);
      run_tx("t2", 1'b1, 8'hF0, 4'd3, 0, -1);
      run_tx("t3", 1'b1, 8'hA5, 4'd1, 1, -1);
      run_tx("t4", 1'b1, 8'h5A, 4'd0, 0, -1);

      // Load and start mid-word must be ignored
      run_tx("t5a", 1'b1, 8'hA5, 4'd1, 0, int'(P) + 3);
      // Load with simultaneous start in IDLE: load only
      setar_palavra = 1'b1; start = 1'b1; palavra = 8'h3C; repeticoes = 4'd2;
      @(negedge clk);
      setar_palavra = 1'b0; start = 1'b0;
      m_word = 8'h3C; m_rep = 4'd2;
      chk("t5b_busy", busy, 0);
      chk("t5b_valid", bit_valid, 0);
      chk("t5b_done", done, 0);
      @(negedge clk);
      chk("t5b_busy2", busy, 0);
      run_tx("t5c", 1'b0, '0, '0, 0, -1);

      // Reset after four filler and five word bits
      setar_palavra = 1'b1; palavra = 8'hA5; repeticoes = 4'd2;
      @(negedge clk);
      setar_palavra = 1'b0; start = 1'b1; bit_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (P + 5) @(posedge clk);
      #2;
      chk("t6_midtx_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("t6_rst_bit_out", bit_out, 0);
      chk("t6_rst_valid", bit_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_done", done, 0);
      m_word = '0; m_rep = '0;
      @(negedge clk);
      rst = 1'b0;
      late_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy || bit_valid) late_done++;
      end
      chk("t6_quiet_after_rst", late_done, 0);
      run_tx("t6_norel", 1'b0, '0, '0, 0, -1);

      // Randomized words, copy counts and backpressure
      for (int k = 0; k < 6; k++) begin
         logic [W-1:0] rw;
         logic [3:0]   rr;
         rw = W'($urandom);
         rr = 4'($urandom_range(1, 4));
         run_tx($sformatf("rnd%0d", k), 1'b1, rw, rr, (k % 3 == 0) ? 0 : 2, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
